ex_mem_stage_reg: RTL and testbench

//  Pipeline boundary between execute and memory. Captures the ALU result, the branch-compare bit,
//  the branch target and the control bits, then presents them to the memory stage.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/skid_buffer.sv | 104 ++++++++++
 rtl/ex_mem_stage_reg.sv | 104 ++++++++++
 tb/tb_ex_mem_stage_reg.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the execute/memory pipeline boundary.
//   DATA_WIDTH / REG_ADDR_W : default datapath and register-index widths
//   F3_*                    : funct3 load/store size encodings
//   ex_mem_t                : payload carried from execute to memory
//   sb_state_t              : skid-buffer occupancy, encoded as {main_v, skid_v}
package cpu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] store_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            funct3;
  } ex_mem_t;

  // The encoding doubles as the valid bits: bit 1 = main_v, bit 0 = skid_v.
  typedef enum logic [1:0] {
    SB_EMPTY = 2'b00,
    SB_ONE   = 2'b10,
    SB_FULL  = 2'b11
  } sb_state_t;

  function automatic logic is_unsigned_load(input logic [2:0] f3);
    return (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: generic 2-entry valid/ready buffer with a registered in_ready.
//   clk, rst_n           : clock, async active-low reset
//   flush                : empties both slots on the next edge, drops in_valid
//   in_valid/in_ready    : upstream handshake (in_ready = ~skid_v)
//   in_data              : payload of type T
//   out_valid/out_ready  : downstream handshake
//   out_data             : payload, always driven from the main slot
module skid_buffer
  import cpu_pkg::*;
#(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  sb_state_t state, state_nxt;
  T          main_p1;
  T          skid_p1;
  logic      accept;
  logic      drain;
  logic      load_main_in;
  logic      load_main_skid;
  logic      load_skid;

  // Both handshake outputs decode straight from the state flop.
  assign in_ready  = ~state[0];
  assign out_valid = state[1];
  assign out_data  = main_p1;

  assign accept = in_valid & in_ready & ~flush;
  assign drain  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SB_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = SB_EMPTY;
    end else begin
      case (state)
        SB_EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_nxt    = SB_ONE;
          end
        end
        SB_ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = SB_FULL;
          end else if (drain) begin
            state_nxt = SB_EMPTY;
          end
        end
        SB_FULL: begin
          // in_ready is low here, so nothing can arrive; the skid entry
          // moves up behind the departing main entry to keep order.
          if (drain) begin
            load_main_skid = 1'b1;
            state_nxt      = SB_ONE;
          end
        end
        default: state_nxt = SB_EMPTY;
      endcase
    end
  end

  // ---- stage p1: payload slots ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (load_main_in) begin
        main_p1 <= in_data;
      end else if (load_main_skid) begin
        main_p1 <= skid_p1;
      end
      if (load_skid) begin
        skid_p1 <= in_data;
      end
    end
  end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: execute -> memory pipeline boundary.
//   Upstream : in_valid/in_ready handshake plus ALU result, branch compare,
//              branch target, store data, rd and control bits.
//   Downstream: out_valid/out_ready handshake plus the non-branch fields.
//   redirect_valid/redirect_pc : one-cycle fetch redirect for an accepted
//              taken branch (independent of downstream backpressure).
//   fwd_valid/fwd_rd/fwd_data  : forwarding tap from the presented entry.
module ex_mem_stage_reg
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic                  in_branch_taken,
  input  logic                  in_is_branch,
  input  logic [DATA_WIDTH-1:0] in_branch_tgt,
  input  logic [DATA_WIDTH-1:0] in_store_data,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [2:0]            in_funct3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_alu_result,
  output logic [DATA_WIDTH-1:0] out_store_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic [2:0]            out_funct3,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  ex_mem_t in_pl_p0;
  ex_mem_t out_pl_p1;
  logic    accept_p0;
  logic    take_redirect_p0;

  assign in_pl_p0.alu_result = in_alu_result;
  assign in_pl_p0.store_data = in_store_data;
  assign in_pl_p0.rd         = in_rd;
  assign in_pl_p0.reg_write  = in_reg_write;
  assign in_pl_p0.mem_read   = in_mem_read;
  assign in_pl_p0.mem_write  = in_mem_write;
  assign in_pl_p0.funct3     = in_funct3;

  skid_buffer #(
    .T (ex_mem_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl_p0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl_p1)
  );

  // Redirect fires at acceptance time, not at issue, so a stalled entry
  // raises it exactly once; accept already excludes flush.
  assign accept_p0        = in_valid & in_ready & ~flush;
  assign take_redirect_p0 = accept_p0 & in_is_branch & in_branch_taken;

  // ---- stage p1: redirect ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= take_redirect_p0;
      if (take_redirect_p0) begin
        redirect_pc <= in_branch_tgt;
      end
    end
  end

  // Stale control bits of an empty main slot must not reach the memory
  // stage as side-effecting writes.
  assign out_alu_result = out_pl_p1.alu_result;
  assign out_store_data = out_pl_p1.store_data;
  assign out_rd         = out_pl_p1.rd;
  assign out_reg_write  = out_pl_p1.reg_write & out_valid;
  assign out_mem_read   = out_pl_p1.mem_read;
  assign out_mem_write  = out_pl_p1.mem_write & out_valid;
  assign out_funct3     = out_pl_p1.funct3;

  assign fwd_valid = out_valid & out_pl_p1.reg_write & (out_pl_p1.rd != '0);
  assign fwd_rd    = out_pl_p1.rd;
  assign fwd_data  = out_pl_p1.alu_result;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
module tb_ex_mem_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_result;
  logic        in_branch_taken;
  logic        in_is_branch;
  logic [31:0] in_branch_tgt;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [2:0]  in_funct3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu_result;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic [2:0]  out_funct3;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  ex_mem_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_branch_taken(in_branch_taken),
    .in_is_branch(in_is_branch), .in_branch_tgt(in_branch_tgt),
    .in_store_data(in_store_data), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_funct3(in_funct3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_funct3(out_funct3),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  // Reference model: a 2-deep FIFO of accepted entries.
  typedef struct {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
  } ent_t;

  ent_t        q[$];
  logic        exp_redir;
  logic [31:0] exp_pc;
  int          checks = 0;
  int          errors = 0;
  int          pulses;

  typedef struct {
    logic        iv;
    logic [31:0] res;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_res;
    logic        e_ir;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; out_ready = 0;
    in_alu_result = 0; in_branch_taken = 0; in_is_branch = 0; in_branch_tgt = 0;
    in_store_data = 0; in_rd = 5'd1; in_reg_write = 1; in_mem_read = 0;
    in_mem_write = 0; in_funct3 = 3'b010;
  endtask

  task automatic check_model();
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, exp_redir});
    if (exp_redir) chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, exp_pc});
    if (q.size() > 0) begin
      chk("out_alu_result", {32'd0, out_alu_result}, {32'd0, q[0].res});
      chk("out_store_data", {32'd0, out_store_data}, {32'd0, q[0].sd});
      chk("out_rd", {59'd0, out_rd}, {59'd0, q[0].rd});
      chk("out_reg_write", {63'd0, out_reg_write}, {63'd0, q[0].rw});
      chk("out_mem_read", {63'd0, out_mem_read}, {63'd0, q[0].mr});
      chk("out_mem_write", {63'd0, out_mem_write}, {63'd0, q[0].mw});
      chk("out_funct3", {61'd0, out_funct3}, {61'd0, q[0].f3});
      chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, q[0].rw && (q[0].rd != 0)});
      chk("fwd_rd", {59'd0, fwd_rd}, {59'd0, q[0].rd});
      chk("fwd_data", {32'd0, fwd_data}, {32'd0, q[0].res});
    end else begin
      chk("out_reg_write_idle", {63'd0, out_reg_write}, 64'd0);
      chk("out_mem_write_idle", {63'd0, out_mem_write}, 64'd0);
      chk("fwd_valid_idle", {63'd0, fwd_valid}, 64'd0);
    end
  endtask

  // Call just after a negedge with inputs driven; advances one clock.
  task automatic step();
    int   n;
    logic acc;
    logic drn;
    ent_t e;
    n   = q.size();
    acc = in_valid && (n < 2) && !flush;
    drn = (n > 0) && out_ready;
    e.res = in_alu_result; e.sd = in_store_data; e.rd = in_rd;
    e.rw = in_reg_write; e.mr = in_mem_read; e.mw = in_mem_write; e.f3 = in_funct3;
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    exp_redir = acc && in_is_branch && in_branch_taken;
    if (exp_redir) exp_pc = in_branch_tgt;
    @(negedge clk);
    check_model();
  endtask

  task automatic drain_all();
    idle_inputs();
    out_ready = 1;
    step();
    step();
    step();
  endtask

  initial begin
    idle_inputs();
    exp_redir = 0;
    exp_pc = 0;
    rst_n = 0;
    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_redirect", {63'd0, redirect_valid}, 64'd0);
    chk("rst_data", {32'd0, out_alu_result}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Streaming: results 1..8 back to back, out_ready held high.
    for (int i = 1; i <= 8; i++) begin
      idle_inputs();
      out_ready = 1; in_valid = 1; in_alu_result = i;
      step();
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_result", {32'd0, out_alu_result}, i);
      chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
    end
    drain_all();

    // Backpressure table.
    tbl[0] = '{1'b1, 32'h11, 1'b0, 1'b1, 32'h11, 1'b1};
    tbl[1] = '{1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 1'b0};
    tbl[2] = '{1'b1, 32'h33, 1'b0, 1'b1, 32'h11, 1'b0};
    tbl[3] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h22, 1'b1};
    tbl[4] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1};
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      in_valid = tbl[i].iv; in_alu_result = tbl[i].res; out_ready = tbl[i].ordy;
      step();
      chk($sformatf("bp%0d_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].e_ov});
      chk($sformatf("bp%0d_in_ready", i), {63'd0, in_ready}, {63'd0, tbl[i].e_ir});
      if (tbl[i].e_ov) chk($sformatf("bp%0d_result", i), {32'd0, out_alu_result}, {32'd0, tbl[i].e_res});
    end

    // Taken branch while stalled: one pulse only.
    idle_inputs();
    in_valid = 1; in_is_branch = 1; in_branch_taken = 1; in_branch_tgt = 32'h100;
    in_reg_write = 0; in_alu_result = 32'h55;
    pulses = 0;
    step();
    if (redirect_valid) pulses++;
    chk("br_pc", {32'd0, redirect_pc}, 64'h100);
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      step();
      if (redirect_valid) pulses++;
    end
    chk("br_pulses", pulses, 64'd1);
    chk("br_still_held", {63'd0, out_valid}, 64'd1);
    drain_all();

    // Flush in FULL with an incoming valid.
    idle_inputs();
    in_valid = 1; in_alu_result = 32'hA1; step();
    in_alu_result = 32'hA2; step();
    chk("fl_full", {63'd0, in_ready}, 64'd0);
    in_alu_result = 32'hA3; flush = 1; step();
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
    idle_inputs(); out_ready = 1;
    step(); step();
    chk("fl_never_appears", {63'd0, out_valid}, 64'd0);
    // Flush colliding with a taken branch.
    idle_inputs();
    in_valid = 1; flush = 1; in_is_branch = 1; in_branch_taken = 1; in_branch_tgt = 32'h200;
    step();
    chk("fl_no_redirect", {63'd0, redirect_valid}, 64'd0);
    chk("fl_br_dropped", {63'd0, out_valid}, 64'd0);

    // Forwarding.
    idle_inputs();
    in_valid = 1; in_rd = 5'd5; in_reg_write = 1; in_alu_result = 32'hDEAD;
    step();
    chk("fwd_valid", {63'd0, fwd_valid}, 64'd1);
    chk("fwd_rd", {59'd0, fwd_rd}, 64'd5);
    chk("fwd_data", {32'd0, fwd_data}, 64'hDEAD);
    drain_all();
    idle_inputs();
    in_valid = 1; in_rd = 5'd0; in_reg_write = 1; in_alu_result = 32'hBEEF;
    step();
    chk("fwd_rd0", {63'd0, fwd_valid}, 64'd0);
    drain_all();

    // Reset mid-traffic with the buffer full and a redirect in flight.
    idle_inputs();
    in_valid = 1; in_alu_result = 32'h71; step();
    in_alu_result = 32'h72; in_is_branch = 1; in_branch_taken = 1; in_branch_tgt = 32'h300;
    step();
    chk("pre_rst_full", {63'd0, in_ready}, 64'd0);
    idle_inputs();
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_redirect", {63'd0, redirect_valid}, 64'd0);
    q.delete();
    exp_redir = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Randomized traffic against the FIFO model.
    for (int i = 0; i < 400; i++) begin
      in_valid        = ($urandom_range(0, 3) != 0);
      out_ready       = ($urandom_range(0, 2) != 0);
      flush           = ($urandom_range(0, 15) == 0);
      in_alu_result   = $urandom;
      in_store_data   = $urandom;
      in_branch_tgt   = $urandom;
      in_is_branch    = $urandom_range(0, 1);
      in_branch_taken = $urandom_range(0, 1);
      in_rd           = $urandom_range(0, 31);
      in_reg_write    = $urandom_range(0, 1);
      in_mem_read     = $urandom_range(0, 1);
      in_mem_write    = $urandom_range(0, 1);
      in_funct3       = $urandom_range(0, 7);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
